// File: rtl/param_input_regs.sv
// Parameter input stage for the DDS synthesizer.
// The host writes into a shadow register set. On COMMIT the shadow set is
// validated and copied atomically to the active set once the generator is
// idle, and a one-cycle start pulse follows. The generator reads the active
// period table through a registered, indexed read port.
module param_input_regs #(
  parameter int N_PERIODS   = 32,
  parameter int ADDR_W      = 6,
  parameter int F_CARRIER_W = 32,
  parameter int T_IMP_W     = 10,
  parameter int NUM_IMP_W   = 6,
  parameter int T_PERIOD_W  = 13,
  parameter int DEV_W       = 22,
  parameter int IDX_W       = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   WR_EN,
  input  logic [ADDR_W-1:0]      WR_ADDR,
  input  logic [31:0]            WR_DATA,
  input  logic                   COMMIT,
  input  logic                   GEN_BUSY,
  input  logic [IDX_W-1:0]       PERIOD_IDX,
  output logic                   SIGN_START_GEN,
  output logic [1:0]             SIGNAL_TYPE,
  output logic [F_CARRIER_W-1:0] F_CARRIER,
  output logic [T_IMP_W-1:0]     T_IMPULSE,
  output logic [NUM_IMP_W-1:0]   NUM_OF_IMP,
  output logic                   VOBULATION,
  output logic [DEV_W-1:0]       DEVIATION,
  output logic [T_PERIOD_W-1:0]  T_PERIOD,
  output logic                   CFG_VALID,
  output logic                   PENDING,
  output logic                   ERR
);

  // Register map
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_FCAR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TIMP = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_NIMP = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_DEV  = ADDR_W'(4);
  // Period table window [TAB_LO, TAB_HI), one extra bit so TAB_HI can reach 2^ADDR_W
  localparam logic [ADDR_W:0]   TAB_LO = (ADDR_W+1)'(16);
  localparam logic [ADDR_W:0]   TAB_HI = (ADDR_W+1)'(16 + N_PERIODS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_START = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Shadow set (host side)
  logic [1:0]             sig_type_sh_q;
  logic                   vob_sh_q;
  logic [F_CARRIER_W-1:0] f_car_sh_q;
  logic [T_IMP_W-1:0]     t_imp_sh_q;
  logic [NUM_IMP_W-1:0]   num_imp_sh_q;
  logic [DEV_W-1:0]       dev_sh_q;

  // Active set (generator side)
  logic [1:0]             sig_type_act_q;
  logic                   vob_act_q;
  logic [F_CARRIER_W-1:0] f_car_act_q;
  logic [T_IMP_W-1:0]     t_imp_act_q;
  logic [NUM_IMP_W-1:0]   num_imp_act_q;
  logic [DEV_W-1:0]       dev_act_q;

  logic [T_PERIOD_W-1:0]  per_act [N_PERIODS];

  logic                   cfg_valid_q;
  logic                   pending_q, pending_d;
  logic                   err_q, err_d;
  logic [T_PERIOD_W-1:0]  t_period_q, t_period_d;
  logic [IDX_W-1:0]       rd_sel;

  logic                   transfer;
  logic                   cfg_ok;
  logic                   load_en;
  logic                   val_err;
  logic                   addr_mapped;
  logic                   wr_unmapped;
  logic [ADDR_W:0]        addr_ext;

  // Address decode: scalar fields at 0..4, period table window above 16
  assign addr_ext    = {1'b0, WR_ADDR};
  assign addr_mapped = (WR_ADDR <= A_DEV) || ((addr_ext >= TAB_LO) && (addr_ext < TAB_HI));
  assign wr_unmapped = WR_EN && !addr_mapped;

  // A zero impulse length or impulse count would stall the generator, so reject it
  assign cfg_ok   = (num_imp_sh_q != '0) && (t_imp_sh_q != '0);
  assign transfer = (COMMIT || pending_q) && !GEN_BUSY && (state_q == S_IDLE);

  // Host writes into the scalar shadow fields
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sig_type_sh_q <= '0;
      vob_sh_q      <= 1'b0;
      f_car_sh_q    <= '0;
      t_imp_sh_q    <= '0;
      num_imp_sh_q  <= '0;
      dev_sh_q      <= '0;
    end else if (WR_EN) begin
      case (WR_ADDR)
        A_CTRL: begin
          sig_type_sh_q <= WR_DATA[1:0];
          vob_sh_q      <= WR_DATA[2];
        end
        A_FCAR:  f_car_sh_q   <= WR_DATA[F_CARRIER_W-1:0];
        A_TIMP:  t_imp_sh_q   <= WR_DATA[T_IMP_W-1:0];
        A_NIMP:  num_imp_sh_q <= WR_DATA[NUM_IMP_W-1:0];
        A_DEV:   dev_sh_q     <= WR_DATA[DEV_W-1:0];
        default: ;
      endcase
    end
  end

  // Atomic copy of the scalar shadow fields into the active set
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sig_type_act_q <= '0;
      vob_act_q      <= 1'b0;
      f_car_act_q    <= '0;
      t_imp_act_q    <= '0;
      num_imp_act_q  <= '0;
      dev_act_q      <= '0;
    end else if (load_en) begin
      sig_type_act_q <= sig_type_sh_q;
      vob_act_q      <= vob_sh_q;
      f_car_act_q    <= f_car_sh_q;
      t_imp_act_q    <= t_imp_sh_q;
      num_imp_act_q  <= num_imp_sh_q;
      dev_act_q      <= dev_sh_q;
    end
  end

  // Period table: one shadow and one active entry per slot
  genvar gi;
  generate
    for (gi = 0; gi < N_PERIODS; gi++) begin : g_tab
      localparam logic [ADDR_W-1:0] ENTRY_ADDR = ADDR_W'(16 + gi);
      logic [T_PERIOD_W-1:0] sh_q;
      logic [T_PERIOD_W-1:0] act_q;

      // Host write to this table slot
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          sh_q <= '0;
        end else if (WR_EN && (WR_ADDR == ENTRY_ADDR)) begin
          sh_q <= WR_DATA[T_PERIOD_W-1:0];
        end
      end

      // Copy this slot into the active table on an accepted transfer
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          act_q <= '0;
        end else if (load_en) begin
          act_q <= sh_q;
        end
      end

      assign per_act[gi] = act_q;
    end
  endgenerate

  // Transfer FSM next state, pending flag and load/validation decisions
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    load_en   = 1'b0;
    val_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          pending_d = 1'b0;
          if (cfg_ok) begin
            load_en = 1'b1;
            state_d = S_ARM;
          end else begin
            val_err = 1'b1;
          end
        end else if (COMMIT) begin
          pending_d = 1'b1;
        end
      end
      S_ARM: begin
        state_d = S_START;
        if (COMMIT) pending_d = 1'b1;
      end
      S_START: begin
        state_d = S_IDLE;
        if (COMMIT) pending_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Both error sources merge into a single next-cycle pulse
  always_comb begin
    err_d = wr_unmapped || val_err;
  end

  // FSM state, pending, error and config-valid registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      if (load_en) cfg_valid_q <= 1'b1;
    end
  end

  // Period read mux: entry 0 without vobulation, out-of-range index reads 0
  always_comb begin
    rd_sel     = vob_act_q ? PERIOD_IDX : '0;
    t_period_d = '0;
    for (int i = 0; i < N_PERIODS; i++) begin
      if (rd_sel == IDX_W'(i)) t_period_d = per_act[i];
    end
  end

  // Registered period read data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      t_period_q <= '0;
    end else begin
      t_period_q <= t_period_d;
    end
  end

  assign SIGN_START_GEN = (state_q == S_START);
  assign SIGNAL_TYPE    = sig_type_act_q;
  assign F_CARRIER      = f_car_act_q;
  assign T_IMPULSE      = t_imp_act_q;
  assign NUM_OF_IMP     = num_imp_act_q;
  assign VOBULATION     = vob_act_q;
  assign DEVIATION      = dev_act_q;
  assign T_PERIOD       = t_period_q;
  assign CFG_VALID      = cfg_valid_q;
  assign PENDING        = pending_q;
  assign ERR            = err_q;

endmodule
